// File: rtl/gpio_pkg.sv
// gpio_pkg -- shared definitions for the GPIO port.
//   REG_* : register indices carried in io_addr[REG_IDX_MSB:REG_IDX_LSB]
//   reg_idx() : extracts the register index from an IO address
package gpio_pkg;
   localparam logic [2:0] REG_DATA = 3'd0;
   localparam logic [2:0] REG_DIR  = 3'd1;
   localparam logic [2:0] REG_SET  = 3'd2;
   localparam logic [2:0] REG_CLR  = 3'd3;
   localparam logic [2:0] REG_TGL  = 3'd4;
   localparam logic [2:0] REG_EVT  = 3'd5;
   localparam logic [2:0] REG_MASK = 3'd6;
   localparam logic [2:0] REG_MODE = 3'd7;

   localparam int REG_IDX_MSB = 15;
   localparam int REG_IDX_LSB = 13;

   function automatic logic [2:0] reg_idx(input logic [15:0] addr);
      return addr[REG_IDX_MSB:REG_IDX_LSB];
   endfunction
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync -- per-pin input conditioning and edge detection.
//   Optional feature macro: GPIO_DEBOUNCE_EN (adds a stable-time filter
//   after the synchroniser; otherwise pin_s is the last synchroniser stage).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   pin_in          : raw asynchronous pad input
//   rise_en/fall_en : edge enables for this pin
//   pin_s           : synchronised (and optionally debounced) pin value
//   rise/fall       : single-cycle edge pulses, already gated by the enables
module gpio_sync #(
   parameter int SYNC      = 2,
   parameter int DB_CYCLES = 120000
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_in,
   input  logic rise_en,
   input  logic fall_en,
   output logic pin_s,
   output logic rise,
   output logic fall
);
   logic [SYNC-1:0] sync_q;
   logic            pin_d;

   always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC-2:0], pin_in};
   end

`ifdef GPIO_DEBOUNCE_EN
   // Counts consecutive cycles the synchronised input disagrees with the
   // accepted value; any return to the accepted value restarts the count.
   localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   logic [CW-1:0] db_cnt;
   logic          db_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         db_cnt <= '0;
         db_q   <= 1'b0;
      end else if (sync_q[SYNC-1] == db_q) begin
         db_cnt <= '0;
      end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
         db_q   <= sync_q[SYNC-1];
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   assign pin_s = db_q;
`else
   localparam int unused_db = DB_CYCLES;
   assign pin_s = sync_q[SYNC-1];
`endif

   always_ff @(posedge clk) begin
      if (reset) pin_d <= 1'b0;
      else       pin_d <= pin_s;
   end

   assign rise = pin_s & ~pin_d & rise_en;
   assign fall = ~pin_s & pin_d & fall_en;
endmodule

// File: rtl/gpio_port.sv
// gpio_port -- parametrised GPIO bank on the j1 IO bus.
//   Optional feature macro: GPIO_DEBOUNCE_EN (per-pin debounce in gpio_sync).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   io_rd, io_wr      : registered 1-cycle IO strobes
//   io_addr           : [SEL_BIT] selects this bank, [15:13] register index
//   io_wdata          : write data
//   io_din            : read data, 0 when not selected (ORed at top level)
//   pin_in            : raw pad inputs
//   pin_out, pin_oe   : pad output values / output enables (1 = drive)
//   irq               : registered level interrupt, |(EVT & MASK)
module gpio_port
   import gpio_pkg::*;
#(
   parameter int W         = 8,
   parameter int SEL_BIT   = 0,
   parameter int SYNC      = 2,
   parameter int DB_CYCLES = 120000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          io_rd,
   input  logic          io_wr,
   input  logic [15:0]   io_addr,
   input  logic [15:0]   io_wdata,
   output logic [15:0]   io_din,
   input  logic [W-1:0]  pin_in,
   output logic [W-1:0]  pin_out,
   output logic [W-1:0]  pin_oe,
   output logic          irq
);
   logic [W-1:0] out_q, dir_q, evt_q, mask_q, rise_en, fall_en;
   logic [W-1:0] pin_s, rise, fall, evt_nxt, wd, fall_wd;
   logic [2:0]   ridx;
   logic [15:0]  rd_data;
   logic         sel, we, irq_q;

   // Reads have no side effects, so the read strobe is not needed; not every
   // address/data bit is decoded either.
   logic unused_bits;
   assign unused_bits = ^{io_rd, io_wdata, io_addr};

   assign sel  = io_addr[SEL_BIT];
   assign we   = io_wr & sel;
   assign ridx = reg_idx(io_addr);
   assign wd   = io_wdata[W-1:0];

   // FALL enables live in MODE[15:8] only when the bank fits in 8 bits.
   always_comb begin
      fall_wd = '0;
      for (int i = 0; i < W; i++)
         if (W <= 8) fall_wd[i] = io_wdata[(i + 8) % 16];
   end

   for (genvar g = 0; g < W; g++) begin : g_pin
      gpio_sync #(.SYNC(SYNC), .DB_CYCLES(DB_CYCLES)) u_sync (
         .clk     (clk),
         .reset   (reset),
         .pin_in  (pin_in[g]),
         .rise_en (rise_en[g]),
         .fall_en (fall_en[g]),
         .pin_s   (pin_s[g]),
         .rise    (rise[g]),
         .fall    (fall[g])
      );
   end

   // Clear is applied before set so a new edge beats a same-cycle W1C.
   always_comb begin
      evt_nxt = evt_q;
      if (we && ridx == REG_EVT) evt_nxt = evt_nxt & ~wd;
      evt_nxt = evt_nxt | rise | fall;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q   <= '0;
         dir_q   <= '0;
         evt_q   <= '0;
         mask_q  <= '0;
         rise_en <= '0;
         fall_en <= '0;
         irq_q   <= 1'b0;
      end else begin
         evt_q <= evt_nxt;
         irq_q <= |(evt_q & mask_q);
         if (we) begin
            case (ridx)
               REG_DATA: out_q   <= wd;
               REG_DIR:  dir_q   <= wd;
               REG_SET:  out_q   <= out_q | wd;
               REG_CLR:  out_q   <= out_q & ~wd;
               REG_TGL:  out_q   <= out_q ^ wd;
               REG_MASK: mask_q  <= wd;
               REG_MODE: begin
                  rise_en <= wd;
                  fall_en <= fall_wd;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rd_data = '0;
      case (ridx)
         REG_DATA:                  rd_data = 16'(pin_s);
         REG_DIR:                   rd_data = 16'(dir_q);
         REG_SET, REG_CLR, REG_TGL: rd_data = 16'(out_q);
         REG_EVT:                   rd_data = 16'(evt_q);
         REG_MASK:                  rd_data = 16'(mask_q);
         REG_MODE: begin
            rd_data = 16'(rise_en);
            for (int i = 0; i < W; i++)
               if (W <= 8) rd_data[(i + 8) % 16] = fall_en[i];
         end
         default: rd_data = '0;
      endcase
   end

   assign io_din  = sel ? rd_data : 16'h0;
   assign pin_out = out_q;
   assign pin_oe  = dir_q;
   assign irq     = irq_q;
endmodule

// File: tb/tb_gpio_port.sv
module tb_gpio_port;
   import gpio_pkg::*;

   localparam int W    = 8;
   localparam int SYNC = 2;
`ifdef GPIO_DEBOUNCE_EN
   localparam int DB  = 4;
   localparam int LAT = SYNC + DB;
`else
   localparam int DB  = 120000;
   localparam int LAT = SYNC;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          io_rd, io_wr;
   logic [15:0]   io_addr, io_wdata, io_din;
   logic [W-1:0]  pin_in, pin_out, pin_oe;
   logic          irq;

   int checks = 0;
   int errs   = 0;

   gpio_port #(.W(W), .SEL_BIT(0), .SYNC(SYNC), .DB_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .io_rd(io_rd), .io_wr(io_wr),
      .io_addr(io_addr), .io_wdata(io_wdata), .io_din(io_din),
      .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  wreg;
      logic [15:0] wdata;
      logic [2:0]  rreg;
      logic [15:0] exp_rd;
      logic [7:0]  exp_out;
      logic [7:0]  exp_oe;
   } vec_t;

   vec_t vec [12];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] r, input logic [15:0] d);
      @(negedge clk);
      io_wr = 1'b1; io_addr = {r, 13'h1}; io_wdata = d;
      @(negedge clk);
      io_wr = 1'b0; io_addr = 16'h0; io_wdata = 16'h0;
   endtask

   task automatic rd_chk(input string nm, input logic [2:0] r, input logic [15:0] exp);
      io_addr = {r, 13'h1};
      #1;
      chk(nm, io_din, exp);
      io_addr = 16'h0;
   endtask

   initial begin
      vec[0]  = '{REG_DIR,  16'h00FF, REG_DIR,  16'h00FF, 8'h00, 8'hFF};
      vec[1]  = '{REG_DATA, 16'h00A5, REG_SET,  16'h00A5, 8'hA5, 8'hFF};
      vec[2]  = '{REG_SET,  16'h000F, REG_CLR,  16'h00AF, 8'hAF, 8'hFF};
      vec[3]  = '{REG_CLR,  16'h00A0, REG_TGL,  16'h000F, 8'h0F, 8'hFF};
      vec[4]  = '{REG_TGL,  16'h00FF, REG_SET,  16'h00F0, 8'hF0, 8'hFF};
      vec[5]  = '{REG_DATA, 16'hFF12, REG_TGL,  16'h0012, 8'h12, 8'hFF};
      vec[6]  = '{REG_MASK, 16'hABCD, REG_MASK, 16'h00CD, 8'h12, 8'hFF};
      vec[7]  = '{REG_MODE, 16'hFFFF, REG_MODE, 16'hFFFF, 8'h12, 8'hFF};
      vec[8]  = '{REG_MODE, 16'h1234, REG_MODE, 16'h1234, 8'h12, 8'hFF};
      vec[9]  = '{REG_DIR,  16'hFF0F, REG_DIR,  16'h000F, 8'h12, 8'h0F};
      vec[10] = '{REG_MASK, 16'h0001, REG_MASK, 16'h0001, 8'h12, 8'h0F};
      vec[11] = '{REG_MODE, 16'h0001, REG_MODE, 16'h0001, 8'h12, 8'h0F};

      reset = 1'b1; io_rd = 1'b0; io_wr = 1'b0;
      io_addr = 16'h0; io_wdata = 16'h0; pin_in = '0;
      tick(3);
      reset = 1'b0;

      // reset state
      chk("rst pin_out", 16'(pin_out), 16'h0);
      chk("rst pin_oe", 16'(pin_oe), 16'h0);
      chk("rst irq", 16'(irq), 16'h0);
      rd_chk("rst EVT", REG_EVT, 16'h0);
      rd_chk("rst MODE", REG_MODE, 16'h0);

      // register write table
      for (int i = 0; i < 12; i++) begin
         wr(vec[i].wreg, vec[i].wdata);
         chk($sformatf("vec%0d pin_out", i), 16'(pin_out), 16'(vec[i].exp_out));
         chk($sformatf("vec%0d pin_oe", i), 16'(pin_oe), 16'(vec[i].exp_oe));
         rd_chk($sformatf("vec%0d read", i), vec[i].rreg, vec[i].exp_rd);
      end
      rd_chk("table EVT", REG_EVT, 16'h0);

      // rise on pin 0: DATA after LAT, EVT at LAT+1, irq one later, then W1C
      pin_in[0] = 1'b1;
      tick(LAT);
      rd_chk("rise DATA", REG_DATA, 16'h0001);
      rd_chk("rise EVT early", REG_EVT, 16'h0000);
      tick(1);
      rd_chk("rise EVT", REG_EVT, 16'h0001);
      chk("rise irq early", 16'(irq), 16'h0);
      tick(1);
      chk("rise irq", 16'(irq), 16'h1);
      wr(REG_EVT, 16'h0001);
      rd_chk("w1c EVT", REG_EVT, 16'h0000);
      tick(1);
      chk("w1c irq", 16'(irq), 16'h0);

      // new edge in the same cycle as W1C: set wins
      pin_in[0] = 1'b0;
      tick(LAT + 2);
      pin_in[0] = 1'b1;
      tick(LAT);
      io_wr = 1'b1; io_addr = {REG_EVT, 13'h1}; io_wdata = 16'h0001;
      @(negedge clk);
      io_wr = 1'b0; io_addr = 16'h0; io_wdata = 16'h0;
      rd_chk("collide EVT", REG_EVT, 16'h0001);
      wr(REG_EVT, 16'h0001);
      rd_chk("collide clr", REG_EVT, 16'h0000);

      // fall-only on pin 7
      pin_in[7] = 1'b1;
      tick(LAT + 2);
      wr(REG_MODE, 16'h8000);
      rd_chk("fall MODE", REG_MODE, 16'h8000);
      pin_in[7] = 1'b0;
      tick(LAT + 2);
      rd_chk("fall EVT", REG_EVT, 16'h0080);
      chk("fall irq masked", 16'(irq), 16'h0);
      wr(REG_EVT, 16'h0080);
      rd_chk("fall clr", REG_EVT, 16'h0000);
      pin_in[7] = 1'b1;
      tick(LAT + 2);
      rd_chk("rise ignored", REG_EVT, 16'h0000);
      rd_chk("pins DATA", REG_DATA, 16'h0081);

      // deselected write and read
      wr(REG_DATA, 16'h003C);
      chk("sel write", 16'(pin_out), 16'h003C);
      @(negedge clk);
      io_wr = 1'b1; io_addr = {REG_DATA, 13'h0}; io_wdata = 16'h0055;
      @(negedge clk);
      io_wr = 1'b0; io_wdata = 16'h0;
      chk("desel write", 16'(pin_out), 16'h003C);
      io_addr = {REG_DIR, 13'h0};
      #1;
      chk("desel io_din", io_din, 16'h0000);
      io_addr = 16'h0;

      // build up interrupt state, then reset mid-write
      wr(REG_MODE, 16'h0002);
      wr(REG_MASK, 16'h00FF);
      pin_in[1] = 1'b1;
      tick(LAT + 3);
      chk("pre-rst irq", 16'(irq), 16'h1);
      @(negedge clk);
      reset = 1'b1; io_wr = 1'b1; io_addr = {REG_DATA, 13'h1}; io_wdata = 16'h00FF;
      @(negedge clk);
      reset = 1'b0; io_wr = 1'b0; io_addr = 16'h0; io_wdata = 16'h0;
      chk("mid-rst pin_out", 16'(pin_out), 16'h0);
      chk("mid-rst pin_oe", 16'(pin_oe), 16'h0);
      chk("mid-rst irq", 16'(irq), 16'h0);
      rd_chk("mid-rst EVT", REG_EVT, 16'h0);
      rd_chk("mid-rst MASK", REG_MASK, 16'h0);

`ifdef GPIO_DEBOUNCE_EN
      // debounce: short glitch ignored, long level accepted
      tick(LAT + 3);
      wr(REG_MODE, 16'h0004);
      rd_chk("db EVT start", REG_EVT, 16'h0);
      pin_in[2] = 1'b1;
      tick(3);
      pin_in[2] = 1'b0;
      tick(10);
      rd_chk("db glitch DATA", REG_DATA, 16'h0083);
      rd_chk("db glitch EVT", REG_EVT, 16'h0000);
      pin_in[2] = 1'b1;
      tick(LAT + 2);
      rd_chk("db level DATA", REG_DATA, 16'h0087);
      rd_chk("db level EVT", REG_EVT, 16'h0004);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
